// File: rtl/ct_mat_pkg.sv
// Shared types and constants for the matrix memory response unit.
package ct_mat_pkg;

   // Controller states, also exported on the debug port of the top.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_FLUSH = 3'd4
   } mat_state_e;

   localparam logic [1:0] MAT_LSU_LOAD  = 2'b01;
   localparam logic [1:0] MAT_LSU_STORE = 2'b10;

   // Matrix access descriptor as presented by the LSU.
   typedef struct packed {
      logic [6:0]  iid;
      logic [1:0]  typ;
      logic [2:0]  mreg;
      logic [63:0] base;
      logic [7:0]  rows;
      logic [63:0] stride;
      logic [15:0] row_bytes;
      logic        nf_vld;
      logic [2:0]  nf;
   } mat_desc_t;

   // Only loads and stores generate memory traffic.
   function automatic logic is_mem_type(input logic [1:0] t);
      return (t == MAT_LSU_LOAD) || (t == MAT_LSU_STORE);
   endfunction

endpackage

// File: rtl/ct_mat_addr_gen.sv
// Row/column walker: turns a latched descriptor into a sequence of beats.
// Beat fields are pure functions of registers, so they hold still until
// the controller pulses advance_i on a handshake.
module ct_mat_addr_gen
   import ct_mat_pkg::*;
#(
   parameter int BEAT_BYTES = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        advance_i,
   input  logic [63:0] base_i,
   input  logic [63:0] stride_i,
   input  logic [15:0] row_bytes_i,
   input  logic [7:0]  rows_i,
   input  logic        nf_vld_i,
   input  logic [2:0]  nf_i,
   output logic [63:0] addr_o,
   output logic [6:0]  bytes_o,
   output logic [10:0] row_o,
   output logic [15:0] col_o,
   output logic        last_beat_o,
   output logic        last_row_o
);

   localparam logic [15:0] BEAT_W16 = 16'(BEAT_BYTES);
   localparam logic [6:0]  BEAT_W7  = 7'(BEAT_BYTES);

   logic [63:0] row_addr_q;
   logic [63:0] stride_q;
   logic [15:0] row_bytes_q;
   logic [15:0] col_q;
   logic [10:0] row_q;
   logic [10:0] total_rows_q;
   logic [15:0] remain;
   logic [10:0] total_rows_d;
   logic [63:0] stride_d;

   // Whole-register mode walks rows*(nf+1) rows back to back.
   always_comb begin
      total_rows_d = {3'd0, rows_i};
      stride_d     = stride_i;
      if (nf_vld_i) begin
         total_rows_d = {3'd0, rows_i} * ({8'd0, nf_i} + 11'd1);
         stride_d     = {48'd0, row_bytes_i};
      end
   end

   assign remain      = row_bytes_q - col_q;
   assign addr_o      = row_addr_q + {48'd0, col_q};
   assign bytes_o     = (remain >= BEAT_W16) ? BEAT_W7 : remain[6:0];
   assign row_o       = row_q;
   assign col_o       = col_q;
   assign last_beat_o = (remain <= BEAT_W16);
   assign last_row_o  = (row_q == (total_rows_q - 11'd1));

   // Latch on load, then step column, wrapping to the next row on its last beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         row_addr_q   <= '0;
         stride_q     <= '0;
         row_bytes_q  <= '0;
         col_q        <= '0;
         row_q        <= '0;
         total_rows_q <= '0;
      end else if (load_i) begin
         row_addr_q   <= base_i;
         stride_q     <= stride_d;
         row_bytes_q  <= row_bytes_i;
         col_q        <= '0;
         row_q        <= '0;
         total_rows_q <= total_rows_d;
      end else if (advance_i) begin
         if (last_beat_o) begin
            col_q      <= '0;
            row_q      <= row_q + 11'd1;
            row_addr_q <= row_addr_q + stride_q;
         end else begin
            col_q <= col_q + BEAT_W16;
         end
      end
   end

endmodule

// File: rtl/ct_mat_mem_resp_unit.sv
// Matrix load/store responder: one descriptor at a time, beats issued on a
// single memory port, one completion per descriptor, silent abort on flush.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; a raised valid and its payload stay unchanged until accepted,
// except that a flush withdraws mem_req_vld and cancels the beat in flight.
module ct_mat_mem_resp_unit
   import ct_mat_pkg::*;
#(
   parameter int BEAT_BYTES = 64,
   parameter int MAX_OUTST  = 8
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst,
   input  logic        rtu_yy_xx_flush,
   input  logic        req_vld,
   output logic        req_rdy,
   input  logic [6:0]  req_iid,
   input  logic [1:0]  req_type,
   input  logic [2:0]  req_mreg,
   input  logic [63:0] req_base,
   input  logic [7:0]  req_rows,
   input  logic [63:0] req_stride,
   input  logic [15:0] req_row_bytes,
   input  logic        req_nf_vld,
   input  logic [2:0]  req_nf,
   output logic        mem_req_vld,
   input  logic        mem_req_rdy,
   output logic [63:0] mem_req_addr,
   output logic [6:0]  mem_req_bytes,
   output logic        mem_req_wr,
   output logic [2:0]  mem_req_mreg,
   output logic [10:0] mem_req_row,
   output logic [15:0] mem_req_col,
   input  logic        mem_resp_vld,
   output logic        done_vld,
   output logic [6:0]  done_iid,
   output mat_state_e  dbg_state_o
);

   localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTST);

   mat_state_e state_q;
   mat_desc_t  req_desc;
   logic       req_rdy_q, mem_req_vld_q, done_vld_q;
   logic [6:0] iid_q, done_iid_q;
   logic       wr_q;
   logic [2:0] mreg_q;
   logic [3:0] outst_q, outst_d;
   logic       accept, degenerate, beat_hs, resp_eff, last_beat, last_row;

   assign req_desc = '{iid: req_iid, typ: req_type, mreg: req_mreg, base: req_base,
                       rows: req_rows, stride: req_stride, row_bytes: req_row_bytes,
                       nf_vld: req_nf_vld, nf: req_nf};

   assign accept     = (state_q == ST_IDLE) && req_rdy_q && req_vld && !rtu_yy_xx_flush;
   assign degenerate = (req_desc.rows == 8'd0) || (req_desc.row_bytes == 16'd0) ||
                       !is_mem_type(req_desc.typ);
   // A flush cancels the beat presented in the same cycle.
   assign beat_hs    = mem_req_vld_q && mem_req_rdy && !rtu_yy_xx_flush;
   // Stray responses with nothing outstanding are dropped.
   assign resp_eff   = mem_resp_vld && (outst_q != 4'd0);

   ct_mat_addr_gen #(.BEAT_BYTES(BEAT_BYTES)) u_addr_gen (
      .clk_i       (forever_cpuclk),
      .rst_i       (cpurst),
      .load_i      (accept && !degenerate),
      .advance_i   (beat_hs),
      .base_i      (req_desc.base),
      .stride_i    (req_desc.stride),
      .row_bytes_i (req_desc.row_bytes),
      .rows_i      (req_desc.rows),
      .nf_vld_i    (req_desc.nf_vld),
      .nf_i        (req_desc.nf),
      .addr_o      (mem_req_addr),
      .bytes_o     (mem_req_bytes),
      .row_o       (mem_req_row),
      .col_o       (mem_req_col),
      .last_beat_o (last_beat),
      .last_row_o  (last_row)
   );

   // Outstanding beats: +1 per issued beat, -1 per response, net zero if both.
   always_comb begin
      outst_d = outst_q;
      if (beat_hs && !resp_eff) outst_d = outst_q + 4'd1;
      else if (!beat_hs && resp_eff) outst_d = outst_q - 4'd1;
   end

   // Controller FSM with registered handshake and completion outputs.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q       <= ST_IDLE;
         req_rdy_q     <= 1'b1;
         mem_req_vld_q <= 1'b0;
         done_vld_q    <= 1'b0;
         done_iid_q    <= '0;
         iid_q         <= '0;
         wr_q          <= 1'b0;
         mreg_q        <= '0;
         outst_q       <= '0;
      end else begin
         outst_q    <= outst_d;
         done_vld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  iid_q     <= req_desc.iid;
                  wr_q      <= (req_desc.typ == MAT_LSU_STORE);
                  mreg_q    <= req_desc.mreg;
                  req_rdy_q <= 1'b0;
                  if (degenerate) begin
                     state_q    <= ST_DONE;
                     done_vld_q <= 1'b1;
                     done_iid_q <= req_desc.iid;
                  end else begin
                     state_q       <= ST_ISSUE;
                     mem_req_vld_q <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (rtu_yy_xx_flush) begin
                  mem_req_vld_q <= 1'b0;
                  state_q       <= (outst_d != 4'd0) ? ST_FLUSH : ST_IDLE;
                  req_rdy_q     <= (outst_d == 4'd0);
               end else if (beat_hs && last_beat && last_row) begin
                  mem_req_vld_q <= 1'b0;
                  state_q       <= ST_WAIT;
               end else begin
                  mem_req_vld_q <= (outst_d != OUTST_MAX);
               end
            end
            ST_WAIT: begin
               if (rtu_yy_xx_flush) begin
                  state_q   <= (outst_d != 4'd0) ? ST_FLUSH : ST_IDLE;
                  req_rdy_q <= (outst_d == 4'd0);
               end else if (outst_d == 4'd0) begin
                  state_q    <= ST_DONE;
                  done_vld_q <= 1'b1;
                  done_iid_q <= iid_q;
               end
            end
            ST_DONE: begin
               state_q   <= ST_IDLE;
               req_rdy_q <= 1'b1;
            end
            ST_FLUSH: begin
               if (outst_d == 4'd0) begin
                  state_q   <= ST_IDLE;
                  req_rdy_q <= 1'b1;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               req_rdy_q     <= 1'b1;
               mem_req_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_rdy      = req_rdy_q;
   assign mem_req_vld  = mem_req_vld_q;
   assign mem_req_wr   = wr_q;
   assign mem_req_mreg = mreg_q;
   // A flush coinciding with the completion pulse suppresses it.
   assign done_vld     = done_vld_q && !rtu_yy_xx_flush;
   assign done_iid     = done_iid_q;
   assign dbg_state_o  = state_q;

endmodule
